// File: rtl/clint_pkg.sv
// Shared constants, bus FSM encoding and address decode for the core-local interruptor.
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [31:0] addr);
    case (addr)
      CLINT_MSIP:        return SEL_MSIP;
      CLINT_MTIMECMP_LO: return SEL_CMP_LO;
      CLINT_MTIMECMP_HI: return SEL_CMP_HI;
      CLINT_MTIME_LO:    return SEL_MTIME_LO;
      CLINT_MTIME_HI:    return SEL_MTIME_HI;
      default:           return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler producing one mtime increment strobe every TICK_DIV clock cycles.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] count;

  assign tick = (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// CLINT: 64-bit mtime/mtimecmp, msip, and a two-state bus slave with one response pulse per access.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ready,
  output logic              bus_rvalid,
  output logic [31:0]       bus_rdata,
  output logic              bus_err,
  output logic              timer_irq,
  output logic              soft_irq,
  output logic [63:0]       mtime_o
);

  bus_state_e state, state_next;
  reg_sel_e   sel;
  logic       tick;
  logic       accept;
  logic       wr;
  logic       rd;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic        msip;
  logic [31:0] rdata_mux;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign sel     = decode(32'(bus_addr));
  assign accept  = bus_req && bus_ready;
  assign wr      = accept && bus_we;
  assign rd      = accept && !bus_we;
  assign mtime_o = mtime;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus_ready = 1'b1;
        if (bus_req) state_next = ST_RESP;
      end
      ST_RESP: begin
        bus_rvalid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Hi half reads come from the shadow so a lo-then-hi pair is a consistent 64-bit sample.
  always_comb begin
    rdata_mux = '0;
    case (sel)
      SEL_MSIP:     rdata_mux = {31'b0, msip};
      SEL_CMP_LO:   rdata_mux = mtimecmp[31:0];
      SEL_CMP_HI:   rdata_mux = mtimecmp[63:32];
      SEL_MTIME_LO: rdata_mux = mtime[31:0];
      SEL_MTIME_HI: rdata_mux = hi_shadow;
      default:      rdata_mux = '0;
    endcase
  end

  // A bus write to either mtime half suppresses that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime     <= '0;
      hi_shadow <= '0;
    end else begin
      if (wr && sel == SEL_MTIME_LO) begin
        mtime[31:0] <= bus_wdata;
        hi_shadow   <= mtime[63:32];
      end else if (wr && sel == SEL_MTIME_HI) begin
        mtime[63:32] <= bus_wdata;
        hi_shadow    <= bus_wdata;
      end else begin
        if (tick) mtime <= mtime + 64'd1;
        if (rd && sel == SEL_MTIME_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
    end else if (wr) begin
      case (sel)
        SEL_MSIP:   msip            <= bus_wdata[0];
        SEL_CMP_LO: mtimecmp[31:0]  <= bus_wdata;
        SEL_CMP_HI: mtimecmp[63:32] <= bus_wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_rdata <= '0;
      bus_err   <= 1'b0;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      soft_irq  <= msip;
      if (accept) begin
        bus_rdata <= rd ? rdata_mux : 32'd0;
        bus_err   <= (sel == SEL_NONE);
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) on one bus, checked every cycle against a model.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;

  logic [1:0]        ready;
  logic [1:0]        rvalid;
  logic [1:0][31:0]  rdata;
  logic [1:0]        err;
  logic [1:0]        tirq;
  logic [1:0]        sirq;
  logic [1:0][63:0]  mtime;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(ready[0]),
    .bus_rvalid(rvalid[0]), .bus_rdata(rdata[0]), .bus_err(err[0]),
    .timer_irq(tirq[0]), .soft_irq(sirq[0]), .mtime_o(mtime[0])
  );

  clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(ready[1]),
    .bus_rvalid(rvalid[1]), .bus_rdata(rdata[1]), .bus_err(err[1]),
    .timer_irq(tirq[1]), .soft_irq(sirq[1]), .mtime_o(mtime[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as the map describes them, ticks from a cycle count.
  int          div_of [2] = '{1, 4};
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp [2];
  logic [31:0] m_shadow [2];
  logic        m_msip [2];
  logic        m_timer [2];
  logic        m_soft [2];
  logic        m_busy [2];
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  int          m_cyc [2];
  logic        m_seen = 1'b0;

  logic [63:0] o_mtime, o_cmp;
  logic [31:0] o_shadow;
  logic        o_msip, acc, tk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mtime[i] = 0; m_cmp[i] = '1; m_shadow[i] = 0; m_msip[i] = 0;
        m_timer[i] = 0; m_soft[i] = 0; m_busy[i] = 0; m_rdata[i] = 0;
        m_err[i] = 0; m_cyc[i] = 0;
        m_seen = 1'b1;
      end else begin
        tk = (m_cyc[i] % div_of[i]) == div_of[i] - 1;
        m_cyc[i]++;
        o_mtime = m_mtime[i]; o_cmp = m_cmp[i]; o_shadow = m_shadow[i]; o_msip = m_msip[i];
        m_timer[i] = (o_mtime >= o_cmp);
        m_soft[i]  = o_msip;
        if (tk) m_mtime[i] = o_mtime + 1;
        acc = bus_req && !m_busy[i];
        if (acc) begin
          m_err[i] = 0;
          m_rdata[i] = 0;
          case (bus_addr)
            16'h0000: if (bus_we) m_msip[i] = bus_wdata[0]; else m_rdata[i] = {31'b0, o_msip};
            16'h4000: if (bus_we) m_cmp[i][31:0] = bus_wdata; else m_rdata[i] = o_cmp[31:0];
            16'h4004: if (bus_we) m_cmp[i][63:32] = bus_wdata; else m_rdata[i] = o_cmp[63:32];
            16'hBFF8: begin
              if (bus_we) m_mtime[i] = {o_mtime[63:32], bus_wdata};
              else m_rdata[i] = o_mtime[31:0];
              m_shadow[i] = o_mtime[63:32];
            end
            16'hBFFC: begin
              if (bus_we) begin
                m_mtime[i] = {bus_wdata, o_mtime[31:0]};
                m_shadow[i] = bus_wdata;
              end else begin
                m_rdata[i] = o_shadow;
              end
            end
            default: m_err[i] = 1;
          endcase
        end
        m_busy[i] = acc;
      end
    end
  end

  always @(negedge clk) begin
    if (m_seen) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("d%0d_ready", i),  64'(ready[i]),  64'(!m_busy[i]));
        check($sformatf("d%0d_rvalid", i), 64'(rvalid[i]), 64'(m_busy[i]));
        check($sformatf("d%0d_rdata", i),  64'(rdata[i]),  64'(m_rdata[i]));
        check($sformatf("d%0d_err", i),    64'(err[i]),    64'(m_err[i]));
        check($sformatf("d%0d_timer", i),  64'(tirq[i]),   64'(m_timer[i]));
        check($sformatf("d%0d_soft", i),   64'(sirq[i]),   64'(m_soft[i]));
        check($sformatf("d%0d_mtime", i),  mtime[i],       m_mtime[i]);
      end
    end
  end

  // Caller is #1 after a posedge with the bus idle; returns #1 after the response edge.
  task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    @(posedge clk); #1;
    bus_req = 1'b0;
    check("xfer_rvalid", 64'(rvalid[0]), 64'd1);
    rd = rdata[0];
    er = err[0];
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          k;
    bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) @(posedge clk);
    #1;
    check("t1_mtime0", mtime[0], 64'd10);
    check("t1_mtime1", mtime[1], 64'd2);
    check("t1_timer", 64'(tirq[0]), 64'd0);
    check("t1_soft", 64'(sirq[0]), 64'd0);
    check("t1_ready", 64'(ready[0]), 64'd1);

    // Timer compare and one-cycle lag on clear
    bus_xfer(1'b1, 16'h4000, 32'd20, rd, er);
    bus_xfer(1'b1, 16'h4004, 32'd0, rd, er);
    k = 0;
    while (mtime[0] != 64'd20 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("t2_reach20", mtime[0], 64'd20);
    check("t2_irq_before", 64'(tirq[0]), 64'd0);
    @(posedge clk); #1;
    check("t2_irq_rise", 64'(tirq[0]), 64'd1);
    bus_xfer(1'b1, 16'h4004, 32'd1, rd, er);
    check("t2_irq_clear", 64'(tirq[0]), 64'd0);

    // 64-bit carry and atomic lo/hi read
    bus_xfer(1'b1, 16'hBFFC, 32'd0, rd, er);
    bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFE, rd, er);
    repeat (2) @(posedge clk);
    #1;
    check("t3_carry", mtime[0], 64'h1_0000_0001);
    bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFD, rd, er);
    bus_xfer(1'b0, 16'hBFF8, 32'd0, rd, er);
    check("t3_rd_lo", 64'(rd), 64'hFFFF_FFFE);
    bus_xfer(1'b0, 16'hBFFC, 32'd0, rd, er);
    check("t3_rd_hi_shadow", 64'(rd), 64'd1);
    check("t3_live", mtime[0], 64'h2_0000_0002);

    // Software interrupt
    bus_xfer(1'b1, 16'h0000, 32'hFFFF_FFFF, rd, er);
    check("t4_soft_set", 64'(sirq[0]), 64'd1);
    bus_xfer(1'b0, 16'h0000, 32'd0, rd, er);
    check("t4_msip_rd", 64'(rd), 64'd1);
    bus_xfer(1'b1, 16'h0000, 32'd0, rd, er);
    check("t4_soft_clr", 64'(sirq[0]), 64'd0);

    // Unmapped offset
    bus_xfer(1'b0, 16'h1234, 32'd0, rd, er);
    check("t5_rd_data", 64'(rd), 64'd0);
    check("t5_rd_err", 64'(er), 64'd1);
    bus_xfer(1'b1, 16'h1234, 32'hDEAD_BEEF, rd, er);
    check("t5_wr_err", 64'(er), 64'd1);
    bus_xfer(1'b0, 16'h4000, 32'd0, rd, er);
    check("t5_cmp_lo", 64'(rd), 64'd20);
    check("t5_ok_err", 64'(er), 64'd0);
    bus_xfer(1'b0, 16'h4004, 32'd0, rd, er);
    check("t5_cmp_hi", 64'(rd), 64'd1);

    // Random traffic, request may stay high through RESP
    for (int n = 0; n < 600; n++) begin
      bus_req = ($urandom_range(0, 3) != 0);
      bus_we  = $urandom_range(0, 1);
      case ($urandom_range(0, 6))
        0: bus_addr = 16'h0000;
        1: bus_addr = 16'h4000;
        2: bus_addr = 16'h4004;
        3: bus_addr = 16'hBFF8;
        4: bus_addr = 16'hBFFC;
        default: bus_addr = 16'($urandom_range(0, 16383) << 2);
      endcase
      bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      @(posedge clk); #1;
    end
    bus_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during RESP
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'hBFF8;
    @(posedge clk); #1;
    bus_req = 1'b0;
    check("t6_in_resp", 64'(rvalid[0]), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_rst_rvalid%0d", i), 64'(rvalid[i]), 64'd0);
      check($sformatf("t6_rst_ready%0d", i),  64'(ready[i]),  64'd1);
      check($sformatf("t6_rst_mtime%0d", i),  mtime[i],       64'd0);
      check($sformatf("t6_rst_rdata%0d", i),  64'(rdata[i]),  64'd0);
      check($sformatf("t6_rst_irq%0d", i),    64'({tirq[i], sirq[i], err[i]}), 64'd0);
    end

    // Write mtime lo on the TICK_DIV=4 tick edge
    repeat (3) @(posedge clk);
    #1;
    bus_xfer(1'b1, 16'hBFF8, 32'h100, rd, er);
    check("t6_wr_wins", mtime[1], 64'h100);
    repeat (2) @(posedge clk);
    #1;
    check("t6_hold", mtime[1], 64'h100);
    @(posedge clk); #1;
    check("t6_next_tick", mtime[1], 64'h101);
    bus_xfer(1'b0, 16'h4004, 32'd0, rd, er);
    check("t6_cmp_rst", 64'(rd), 64'hFFFF_FFFF);
    bus_xfer(1'b0, 16'h0000, 32'd0, rd, er);
    check("t6_msip_rst", 64'(rd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor (CLINT) for the single-hart core.
- Owns the 64-bit machine timer `mtime`, the compare register `mtimecmp` and the software-interrupt bit `msip`, all memory-mapped on the data bus.
- Drives the timer-pending and software-pending lines into the CSR block's `mip` bits 7 and 3.
- Exports `mtime` for the read-only `time`/`timeh` CSRs.

Parameters:
- TICK_DIV, 1, number of clk cycles per `mtime` increment; legal range 1..65535.
- ADDR_W, 16, width of the bus offset address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bus_req  in  1  request valid
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  ADDR_W  byte offset inside the CLINT window; word aligned
- bus_wdata  in  32  write data; full-word writes only
- bus_ready  out  1  request accepted this cycle when bus_req && bus_ready
- bus_rvalid  out  1  one-cycle response pulse, issued for reads and writes
- bus_rdata  out  32  read data, valid with bus_rvalid
- bus_err  out  1  unmapped-offset flag, valid with bus_rvalid
- timer_irq  out  1  machine timer interrupt pending (to mip[7])
- soft_irq  out  1  machine software interrupt pending (to mip[3])
- mtime_o  out  64  current mtime value

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; a request in the reset cycle is dropped.
- Reset values:
  - mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, hi-shadow = 0.
  - bus_ready = 1, bus_rvalid = 0, bus_rdata = 0, bus_err = 0, timer_irq = 0, soft_irq = 0.
- Register map (offsets):
  - 0x0000 msip; bit 0 RW, other bits read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset: read returns 0, write is ignored, bus_err = 1 with the response.
- Bus state machine, IDLE/RESP:
  - IDLE: bus_ready = 1. On bus_req, perform the access and go to RESP.
  - RESP: bus_rvalid = 1, bus_ready = 0, then return to IDLE.
  - Throughput is one transaction per 2 cycles. Latency is accept edge + 1 cycle to rvalid.
  - Register writes take effect at the accept edge.
  - bus_rdata and bus_err hold their values outside RESP.
- Tick generation:
  - The prescaler counts 0..TICK_DIV-1. tick = 1 when prescaler == TICK_DIV-1, and the prescaler then wraps to 0.
  - With TICK_DIV = 1, tick is asserted every cycle.
  - On tick, mtime <= mtime + 1 with a full 64-bit carry; wrap from 2^64-1 to 0 is silent.
- mtime write vs tick:
  - A bus write to either mtime half wins over a tick in the same cycle. The written half takes bus_wdata, the other half is unchanged, and there is no increment that cycle.
  - The prescaler is not reset by the write.
- Atomic 64-bit read:
  - Reading mtime lo returns mtime[31:0] and snapshots mtime[63:32] into the hi-shadow at the same edge.
  - Reading mtime hi returns the hi-shadow, not live mtime.
  - Any write to mtime also loads the hi-shadow with the new mtime[63:32].
- timer_irq:
  - Registered: timer_irq <= (mtime >= mtimecmp), evaluated on the values before the edge. It therefore lags register updates by one cycle.
  - Comparison is unsigned 64-bit.
  - Writing mtimecmp above mtime clears timer_irq on the cycle after the next edge; there is no sticky state.
- soft_irq: soft_irq = msip registered, so it follows an msip write one cycle later.
- mtime_o: driven directly from the mtime register.
- Reset mid-transaction: a pending RESP is dropped, bus_rvalid = 0 and the FSM returns to IDLE.

Decomposition:
- Package `clint_pkg` holds:
  - offset constants: CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI;
  - bus FSM state encodings: ST_IDLE, ST_RESP;
  - MTIMECMP_RST = all ones.
- Sub-module `clint_tick_gen` (parameter TICK_DIV; ports clk, reset, tick) holds the prescaler.
- Address decode, registers, comparator and FSM stay in `clint_timer`.

Test Plan:
1. Reset, then idle 10 cycles with TICK_DIV = 1 -> mtime_o = 10, timer_irq = 0, soft_irq = 0, bus_ready = 1.
2. Write 0x4000 = 20 and 0x4004 = 0, then wait -> timer_irq rises the cycle after mtime_o reaches 20. Write 0x4004 = 1 -> timer_irq returns to 0 the cycle after the write edge (one-cycle lag).
3. Write 0xBFF8 = 0xFFFF_FFFE and 0xBFFC = 0, run 3 ticks -> mtime_o = 0x1_0000_0001. Read lo then hi with a tick in between -> the hi read returns the snapshot taken at the lo read.
4. Write 0x0000 = 0xFFFF_FFFF -> soft_irq = 1 one cycle later, read back 0x0000 = 0x1. Write 0 -> soft_irq = 0.
5. Read offset 0x1234 -> bus_rvalid pulse with bus_rdata = 0, bus_err = 1. Write 0x1234 -> no register changes, bus_err = 1.
6. TICK_DIV = 4, write mtime lo on the same cycle as a tick -> the written value persists with no increment, the next increment comes 4 cycles later. Assert reset during RESP -> bus_rvalid = 0 and all registers return to reset values.
